pwm_peripheral: RTL and testbench
=================================

# pwm_peripheral

Consumes the five configuration registers written over SPI and drives the 16 chip outputs. Each output is forced low, forced high, or driven by one shared 8-bit PWM waveform, according to the enable registers. A prescaler sets the PWM period, and the duty cycle is double-buffered so that an SPI write never produces a truncated or glitched pulse.

## Interface
- `PRESCALE`, default 13: clk cycles per PWM counter step (≥1); period = 256·PRESCALE clk (≈3 kHz at 10 MHz).
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en_reg_out_7_0` input 8: output enable, bits 7:0.
- `en_reg_out_15_8` input 8: output enable, bits 15:8.
- `en_reg_pwm_7_0` input 8: PWM mode select, bits 7:0.
- `en_reg_pwm_15_8` input 8: PWM mode select, bits 15:8.
- `pwm_duty_cycle` input 8: requested duty; 0x00 = 0 %, 0xFF = 100 %.
- `out` output 16: registered chip outputs.
- `period_start` output 1: one-clk pulse, registered, marking the first clk of each PWM period.

## Operation
- Inputs are synchronous to `clk`; no internal synchronisers.
- Prescaler `pre_cnt` counts 0..PRESCALE-1.
  - `tick` = (`pre_cnt` == PRESCALE-1).
  - PRESCALE=1 gives `tick` every clk.
- PWM counter `pwm_cnt` is 8 bits and increments on `tick`. It wraps 255→0 on `tick`, with no saturation.
- Duty shadow `duty_q` loads `pwm_duty_cycle` only on `tick` with `pwm_cnt`==255, i.e. at the period boundary.
  - A mid-period write takes effect at the next period.
  - Writes made between boundaries: only the value present at the boundary is used.
- `pwm_sig`:
  - `duty_q`==0xFF → 1.
  - Otherwise `pwm_sig` = (`pwm_cnt` < `duty_q`), so `duty_q`==0 gives constant 0.
- Per bit i, with `en_out` = {`en_reg_out_15_8`, `en_reg_out_7_0`} and `en_pwm` likewise:
  - `en_out[i]`=0 → 0.
  - `en_out[i]`=1 and `en_pwm[i]`=0 → 1.
  - `en_out[i]`=1 and `en_pwm[i]`=1 → `pwm_sig`.
- `en_pwm[i]` is ignored when `en_out[i]`=0.
- Enable changes are not shadowed; they apply at the next clk edge.
- `period_start` is asserted for the clk after `pwm_cnt` wraps to 0.
- Reset (any time, including mid-period):
  - `pre_cnt`=0, `pwm_cnt`=0, `duty_q`=0, `out`=16'h0000, `period_start`=0, all asynchronous.
  - After release, the first period always runs with `duty_q`=0. The requested duty appears from the second period.

## Timing
- `out` is registered and computed from the current-cycle `pwm_cnt`, `duty_q` and enables. Latency from an enable change to `out` is 1 clk.
- After reset release, the first `tick` occurs at the PRESCALE-th rising edge.
- Each period is 256·PRESCALE clk.
- A PWM-mode output:
  - rises 1 clk after `pwm_cnt` becomes 0;
  - is high for exactly `duty_q`·PRESCALE clk (`duty_q` in 1..254);
  - is high for the full period at 0xFF.
- At the boundary, the `duty_q` load and the `pwm_cnt` wrap occur on the same edge, so the new duty governs the whole new period with no glitch.
- Simultaneous enable change and period boundary: both take effect on the same edge.

## Structure
- Package `pwm_pkg`:
  - `PWM_CNT_W`=8;
  - `PWM_CNT_MAX`=8'hFF;
  - `DUTY_FULL`=8'hFF;
  - `NUM_OUT`=16.
- Sub-module `pwm_tick_gen` (parameter PRESCALE; ports `clk`, `rst_n`, `tick`) contains the prescaler.
- Counter, duty shadow and output mux live in the top level.

## Test plan
- Reset: hold `rst_n`=0 with all inputs 0xFF → `out`=0x0000 and `period_start`=0; release → first `period_start` after 256·13 clk.
- Static enables: `en_out`=0xA5C3, `en_pwm`=0 → `out`=0xA5C3 one clk later; then `en_out`=0 → `out`=0x0000.
- 50 % PWM:
  - Stimulus: PRESCALE=13, `en_out`=0xFFFF, `en_pwm`=0x0001, duty 0x80.
  - Wait one full period after reset.
  - Response: `out[0]` high 1664 clk, low 1664 clk; `out[15:1]` constantly 1.
- Extremes:
  - Duty 0x00 → `out[0]` constantly 0 over 3 periods.
  - Duty 0xFF → `out[0]` constantly 1 over 3 periods.
  - Duty 0x01 → `out[0]` high exactly 13 clk per period.
- Mid-period update:
  - Stimulus: duty 0x40 active; write 0xC0 when `pwm_cnt`=0x10, then 0x20 when `pwm_cnt`=0x30.
  - Response: current period high 832 clk; next period high 416 clk; 0xC0 never used.
- Reset mid-period:
  - Stimulus: assert `rst_n` at `pwm_cnt`=0x50 with `out[0]` high.
  - Response: `out` drops to 0 with no clk edge; after release, the first period is low, and the second period follows the programmed duty.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths, limits and the PWM compare rule for the 16-output PWM peripheral.
// Constants and helpers only; no state.
package pwm_pkg;

  localparam int                   PWM_CNT_W   = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_CNT_MAX = 8'hFF;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL   = 8'hFF;
  localparam int                   NUM_OUT     = 16;

  typedef struct packed {
    logic [NUM_OUT-1:0] en_out;
    logic [NUM_OUT-1:0] en_pwm;
  } pwm_en_t;

  // Full-scale duty is special-cased so 0xFF really means 100 %, not 255/256.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: free-running 0..PRESCALE-1 counter, tick combinational on the last count.
// Latency: first tick at the PRESCALE-th edge after reset; no backpressure.
module pwm_tick_gen #(
  parameter int PRESCALE = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int               CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] pre_cnt_d;

  always_comb begin
    tick      = (pre_cnt_q == LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 outputs low, high or from one shared 8-bit PWM with a boundary-shadowed duty.
// Latency: enable change to out is 1 clk; free-running, no backpressure.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   en_reg_out_7_0,
  input  logic [7:0]   en_reg_out_15_8,
  input  logic [7:0]   en_reg_pwm_7_0,
  input  logic [7:0]   en_reg_pwm_15_8,
  input  logic [7:0]   pwm_duty_cycle,
  output logic [15:0]  out,
  output logic         period_start
);

  logic                 tick;
  logic                 wrap;
  logic                 pwm_sig;
  pwm_en_t              en;

  logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_CNT_W-1:0] duty_q, duty_d;
  logic [NUM_OUT-1:0]   out_q, out_d;
  logic                 period_start_q, period_start_d;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Duty load and counter wrap share one edge, so a new period never sees a stale duty.
  always_comb begin
    en.en_out      = {en_reg_out_15_8, en_reg_out_7_0};
    en.en_pwm      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    wrap           = tick && (pwm_cnt_q == PWM_CNT_MAX);
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    duty_d         = wrap ? pwm_duty_cycle : duty_q;
    period_start_d = wrap;
    pwm_sig        = pwm_level(pwm_cnt_q, duty_q);
    out_d          = en.en_out & (~en.en_pwm | {NUM_OUT{pwm_sig}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q      <= '0;
      duty_q         <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_q         <= duty_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboarded bench for pwm_peripheral: per-period high-time and static output checks.
// Expected values are queued as stimulus is applied and compared as periods complete.
module tb_pwm_peripheral;

  localparam int P      = 13;
  localparam int PERIOD = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  en_reg_out_7_0  = 8'h00;
  logic [7:0]  en_reg_out_15_8 = 8'h00;
  logic [7:0]  en_reg_pwm_7_0  = 8'h00;
  logic [7:0]  en_reg_pwm_15_8 = 8'h00;
  logic [7:0]  pwm_duty_cycle  = 8'h00;
  logic [15:0] out;
  logic        period_start;

  int errors = 0;
  int checks = 0;
  int          exp_hi_q[$];
  logic [15:0] exp_out_q[$];

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int model_hi(input logic [7:0] d);
    return (d == 8'hFF) ? PERIOD : int'(d) * P;
  endfunction

  function automatic int pop_hi();
    if (exp_hi_q.size() == 0) return -1;
    return exp_hi_q.pop_front();
  endfunction

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  // From reset release: first period_start must arrive after exactly PERIOD clk.
  task automatic wait_first_period(input string name);
    int  n = 0;
    int  hi = 0;
    int  exp;
    bit  found = 0;
    while (n < PERIOD + 500 && !found) begin
      @(negedge clk);
      n++;
      if (out[0]) hi++;
      if (period_start) found = 1;
    end
    checks++;
    if (!found || n != PERIOD) begin
      errors++;
      $display("FAIL %s_first_start: cycles=%0d found=%0d required %0d", name, n, found, PERIOD);
    end
    exp = pop_hi();
    checks++;
    if (hi !== exp) begin
      errors++;
      $display("FAIL %s_first_period_hi: got %0d required %0d", name, hi, exp);
    end
    exp_hi_q.push_back(model_hi(pwm_duty_cycle));
  endtask

  task automatic sync_period(input string name);
    int n = 0;
    while (n < PERIOD + 500 && !period_start) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!period_start) begin
      errors++;
      $display("FAIL %s_sync: no period_start within %0d clk", name, n);
    end
    exp_hi_q.delete();
    exp_hi_q.push_back(model_hi(pwm_duty_cycle));
  endtask

  // Entered at the negedge where period_start is high; leaves at the next such negedge.
  task automatic measure_period(input string name, input int w1_i, input logic [7:0] w1_v,
                                input int w2_i, input logic [7:0] w2_v,
                                input logic [14:0] exp_rest, output int hi);
    int ps = 0;
    int first_hi = -1;
    int last_hi = -1;
    bit rest_ok = 1;
    int exp;
    hi = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      if (out[0]) begin
        hi++;
        if (first_hi < 0) first_hi = i;
        last_hi = i;
      end
      if (out[15:1] !== exp_rest) rest_ok = 0;
      if (period_start) ps++;
      if (i == w1_i) pwm_duty_cycle = w1_v;
      if (i == w2_i) pwm_duty_cycle = w2_v;
    end
    exp = pop_hi();
    checks++;
    if (hi !== exp) begin
      errors++;
      $display("FAIL %s_hi: got %0d required %0d", name, hi, exp);
    end
    if (exp > 0 && exp < PERIOD) begin
      checks++;
      if (first_hi != 1 || last_hi != exp) begin
        errors++;
        $display("FAIL %s_shape: high from %0d to %0d required 1 to %0d", name, first_hi, last_hi, exp);
      end
    end
    checks++;
    if (ps != 1 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_period_start: pulses=%0d at_end=%0b required 1,1", name, ps, period_start);
    end
    checks++;
    if (!rest_ok) begin
      errors++;
      $display("FAIL %s_rest: out[15:1] deviated, required %h", name, exp_rest);
    end
    exp_hi_q.push_back(model_hi(pwm_duty_cycle));
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    repeat (5) @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_out: got %h required 0000", out);
    end
    checks++;
    if (period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_period_start: got %b required 0", period_start);
    end
    rst_n = 1'b1;
    exp_hi_q.delete();
    exp_hi_q.push_back(0);
    wait_first_period("reset");
  endtask

  // duty_q is 0xFF here, so PWM-mode bits read as 1.
  task automatic test_static();
    logic [15:0] tab_eo[4] = '{16'hA5C3, 16'h0000, 16'h00FF, 16'hFFFF};
    logic [15:0] tab_ep[4] = '{16'h0000, 16'h0000, 16'hFF00, 16'h0F0F};
    logic [15:0] prev;
    logic [15:0] exp;
    for (int k = 0; k < 4; k++) begin
      prev = out;
      set_en(tab_eo[k], tab_ep[k]);
      exp_out_q.push_back(tab_eo[k]);
      #1;
      checks++;
      if (out !== prev) begin
        errors++;
        $display("FAIL static_early_%0d: got %h required %h", k, out, prev);
      end
      @(negedge clk);
      exp = exp_out_q.pop_front();
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL static_%0d: got %h required %h", k, out, exp);
      end
    end
  endtask

  task automatic test_pwm_50();
    int hi;
    set_en(16'hFFFF, 16'h0001);
    pwm_duty_cycle = 8'h80;
    sync_period("pwm50");
    measure_period("pwm50", -1, 8'h00, -1, 8'h00, 15'h7FFF, hi);
    checks++;
    if (PERIOD - hi !== 1664) begin
      errors++;
      $display("FAIL pwm50_low: got %0d required 1664", PERIOD - hi);
    end
    measure_period("pwm50_b", 1000, 8'h00, -1, 8'h00, 15'h7FFF, hi);
  endtask

  task automatic test_extremes();
    int hi;
    measure_period("duty00_a", -1, 8'h00, -1, 8'h00, 15'h7FFF, hi);
    measure_period("duty00_b", -1, 8'h00, -1, 8'h00, 15'h7FFF, hi);
    measure_period("duty00_c", 1000, 8'hFF, -1, 8'h00, 15'h7FFF, hi);
    measure_period("dutyFF_a", -1, 8'h00, -1, 8'h00, 15'h7FFF, hi);
    measure_period("dutyFF_b", -1, 8'h00, -1, 8'h00, 15'h7FFF, hi);
    measure_period("dutyFF_c", 1000, 8'h01, -1, 8'h00, 15'h7FFF, hi);
    measure_period("duty01", 1000, 8'h40, -1, 8'h00, 15'h7FFF, hi);
  endtask

  // 0xC0 is overwritten by 0x20 before the boundary, so it must never be seen.
  task automatic test_mid_update();
    int hi;
    measure_period("mid_cur", 16 * P, 8'hC0, 48 * P, 8'h20, 15'h7FFF, hi);
    measure_period("mid_next", 1000, 8'h80, -1, 8'h00, 15'h7FFF, hi);
  endtask

  task automatic test_reset_mid();
    int hi;
    for (int i = 1; i <= 16'h50 * P + 5; i++) @(negedge clk);
    checks++;
    if (out[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre_high: got %b required 1", out[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: out=%h ps=%b required 0000,0", out, period_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_hi_q.delete();
    exp_hi_q.push_back(0);
    wait_first_period("rstmid");
    measure_period("rstmid_second", -1, 8'h00, -1, 8'h00, 15'h7FFF, hi);
  endtask

  initial begin
    test_reset();
    test_static();
    test_pwm_50();
    test_extremes();
    test_mid_update();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
